// File: rtl/vip_stream_sequencer.sv
// Frame-level sequencer: pops width*height*num_frame pixels from a show-ahead FIFO
// and forwards them through a one-entry output register tagged with sof/eol/eof.
module vip_stream_sequencer #(
  parameter int DWIDTH = 24,
  parameter int DIM_W  = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [DIM_W-1:0]  num_frame,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_empty,
  output logic              in_rdreq,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic [DIM_W-1:0]  frame_idx,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [DIM_W-1:0]  DIM_ZERO  = {DIM_W{1'b0}};
  localparam logic [DIM_W-1:0]  DIM_ONE   = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [DWIDTH-1:0] DATA_ZERO = {DWIDTH{1'b0}};

  logic [1:0]        state_q, state_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [DIM_W-1:0]  nframe_q, nframe_d;
  logic [DIM_W-1:0]  x_q, x_d;
  logic [DIM_W-1:0]  y_q, y_d;
  logic [DIM_W-1:0]  frame_q, frame_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              eol_q, eol_d;
  logic              eof_q, eof_d;
  logic              cfg_err_q, cfg_err_d;
  logic              load_s;
  logic              last_x_s, last_y_s, last_f_s;

  assign last_x_s = (x_q == (width_q - DIM_ONE));
  assign last_y_s = (y_q == (height_q - DIM_ONE));
  assign last_f_s = (frame_q == (nframe_q - DIM_ONE));

  // Next-state logic: job latch, pop/advance rule, output handshake and abort override.
  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    height_d  = height_q;
    nframe_d  = nframe_q;
    x_d       = x_q;
    y_d       = y_q;
    frame_d   = frame_q;
    data_d    = data_q;
    valid_d   = valid_q;
    sof_d     = sof_q;
    eol_d     = eol_q;
    eof_d     = eof_q;
    cfg_err_d = 1'b0;
    load_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          width_d  = width;
          height_d = height;
          nframe_d = num_frame;
          if ((width == DIM_ZERO) || (height == DIM_ZERO) || (num_frame == DIM_ZERO)) begin
            cfg_err_d = 1'b1;
          end else begin
            x_d     = DIM_ZERO;
            y_d     = DIM_ZERO;
            frame_d = DIM_ZERO;
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        load_s = (!valid_q || out_ready) && !in_empty && !abort;
        if (load_s) begin
          data_d  = in_data;
          valid_d = 1'b1;
          sof_d   = (x_q == DIM_ZERO) && (y_q == DIM_ZERO);
          eol_d   = last_x_s;
          eof_d   = last_x_s && last_y_s;
          if (last_x_s) begin
            x_d = DIM_ZERO;
            if (last_y_s) begin
              y_d = DIM_ZERO;
              // The final pixel of the job leaves frame_idx on the last frame.
              if (last_f_s) begin
                state_d = ST_FLUSH;
              end else begin
                frame_d = frame_q + DIM_ONE;
              end
            end else begin
              y_d = y_q + DIM_ONE;
            end
          end else begin
            x_d = x_q + DIM_ONE;
          end
        end else if (out_ready) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      ST_FLUSH: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eol_d   = 1'b0;
      eof_d   = 1'b0;
      x_d     = DIM_ZERO;
      y_d     = DIM_ZERO;
      frame_d = DIM_ZERO;
    end else begin
      cfg_err_d = cfg_err_d;
    end
  end

  // State, job and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      width_q   <= DIM_ZERO;
      height_q  <= DIM_ZERO;
      nframe_q  <= DIM_ZERO;
      x_q       <= DIM_ZERO;
      y_q       <= DIM_ZERO;
      frame_q   <= DIM_ZERO;
      data_q    <= DATA_ZERO;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      height_q  <= height_d;
      nframe_q  <= nframe_d;
      x_q       <= x_d;
      y_q       <= y_d;
      frame_q   <= frame_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
      eof_q     <= eof_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign in_rdreq  = load_s;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_sof   = sof_q;
  assign out_eol   = eol_q;
  assign out_eof   = eof_q;
  assign frame_idx = frame_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_vip_stream_sequencer.sv
// Randomized self-checking bench: a queue-based FIFO and beat-list model of the job.
module tb_vip_stream_sequencer;
  localparam int DW = 24;
  localparam int NW = 11;

  logic          clock = 1'b0;
  logic          reset;
  logic          start, abort, in_empty, out_ready;
  logic [NW-1:0] width, height, num_frame;
  logic [DW-1:0] in_data;
  logic          in_rdreq, out_valid, out_sof, out_eol, out_eof, busy, done, cfg_err;
  logic [DW-1:0] out_data;
  logic [NW-1:0] frame_idx;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW+2:0] exp_q[$];

  vip_stream_sequencer #(.DWIDTH(DW), .DIM_W(NW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .width(width), .height(height), .num_frame(num_frame),
    .in_data(in_data), .in_empty(in_empty), .in_rdreq(in_rdreq),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .frame_idx(frame_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected beats in job order: data from the FIFO, sideband from pixel coordinates.
  task automatic build_job(input int w, input int h, input int nf, input bit seq);
    fifo_q.delete();
    exp_q.delete();
    for (int i = 0; i < w * h * nf; i++) fifo_q.push_back(seq ? DW'(i) : DW'($urandom()));
    for (int f = 0; f < nf; f++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++)
          exp_q.push_back({fifo_q[f*w*h + y*w + x], (x == 0 && y == 0), (x == w-1), (x == w-1 && y == h-1)});
  endtask

  // rmode: 0 always ready, 1 ready pattern 1,0,0,1, 2 random ready and random FIFO gaps.
  task automatic run_job(input int w, input int h, input int nf, input int rmode,
                         input bit seq, input int starve_at, input int abort_beat);
    int total, pops, acc, starve_rem;
    bit full_m, finished, rdy, emp, ab, exp_pop;
    build_job(w, h, nf, seq);
    total = w * h * nf;
    pops = 0; acc = 0; starve_rem = 5; full_m = 1'b0; finished = 1'b0;
    @(negedge clock);
    start = 1'b1; width = NW'(w); height = NW'(h); num_frame = NW'(nf);
    in_empty = 1'b1; abort = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (cyc > 0) @(negedge clock);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      emp = (fifo_q.size() == 0);
      if (rmode == 2 && $urandom_range(0, 3) == 0) emp = 1'b1;
      if (starve_at >= 0 && pops == starve_at && starve_rem > 0) begin
        emp = 1'b1;
        starve_rem--;
      end
      ab = (abort_beat >= 0) && (acc == abort_beat) && full_m;
      if (ab) rdy = 1'b0;
      out_ready = rdy; in_empty = emp; abort = ab;
      in_data = (fifo_q.size() != 0) ? fifo_q[0] : {DW{1'b0}};
      #1;
      exp_pop = !ab && (pops < total) && !emp && (!full_m || rdy);
      if (cyc == 0) check_val("cfg_err_ok", 64'(cfg_err), 64'd0);
      check_val("busy", 64'(busy), 64'd1);
      check_val("done_early", 64'(done), 64'd0);
      check_val("out_valid", 64'(out_valid), 64'(full_m));
      check_val("in_rdreq", 64'(in_rdreq), 64'(exp_pop));
      if (full_m) check_val("beat", 64'({out_data, out_sof, out_eol, out_eof}), 64'(exp_q[acc]));
      if (ab) begin
        @(negedge clock);
        abort = 1'b0; in_empty = 1'b1;
        #1;
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_valid", 64'(out_valid), 64'd0);
        check_val("abort_done", 64'(done), 64'd0);
        @(negedge clock);
        #1;
        check_val("abort_done2", 64'(done), 64'd0);
        return;
      end
      if (exp_pop) begin
        check_val("frame_idx", 64'(frame_idx), 64'(pops / (w * h)));
        pops++;
        void'(fifo_q.pop_front());
      end
      if (full_m && rdy) acc++;
      full_m = exp_pop ? 1'b1 : (rdy ? 1'b0 : full_m);
      if (acc == total) finished = 1'b1;
    end
    if (!finished) begin
      check_val("timeout", 64'd1, 64'd0);
      return;
    end
    @(negedge clock);
    in_empty = 1'b1;
    #1;
    check_val("done_pulse", 64'(done), 64'd1);
    check_val("done_valid", 64'(out_valid), 64'd0);
    check_val("done_rdreq", 64'(in_rdreq), 64'd0);
    @(negedge clock);
    #1;
    check_val("done_clear", 64'(done), 64'd0);
    check_val("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val(tag, 64'({out_data, out_valid, out_sof, out_eol, out_eof, frame_idx, busy, done, cfg_err, in_rdreq}), 64'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; in_empty = 1'b1; out_ready = 1'b1;
    width = '0; height = '0; num_frame = '0; in_data = '0;
    #3;
    check_reset_outputs("reset_state");
    @(negedge clock);
    reset = 1'b1;

    run_job(4, 2, 2, 0, 1'b1, -1, -1);
    run_job(4, 2, 2, 1, 1'b1, -1, -1);
    run_job(4, 2, 2, 0, 1'b1, 6, -1);
    run_job(1, 1, 3, 0, 1'b0, -1, -1);

    // Rejected start: zero height.
    @(negedge clock);
    start = 1'b1; width = 11'd3; height = 11'd0; num_frame = 11'd2;
    in_empty = 1'b0; in_data = 24'h123456;
    @(negedge clock);
    start = 1'b0;
    #1;
    check_val("cfg_err_pulse", 64'(cfg_err), 64'd1);
    check_val("cfg_err_busy", 64'(busy), 64'd0);
    check_val("cfg_err_rdreq", 64'(in_rdreq), 64'd0);
    @(negedge clock);
    #1;
    check_val("cfg_err_clear", 64'(cfg_err), 64'd0);
    check_val("cfg_err_busy2", 64'(busy), 64'd0);
    in_empty = 1'b1;

    run_job(4, 2, 2, 0, 1'b1, -1, 6);
    run_job(4, 2, 2, 0, 1'b1, -1, -1);

    // Asynchronous reset with a stalled beat held in the output register.
    @(negedge clock);
    start = 1'b1; width = 11'd4; height = 11'd2; num_frame = 11'd1;
    in_empty = 1'b0; in_data = 24'hABCDEF; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1;
    check_val("pre_reset_valid", 64'(out_valid), 64'd1);
    check_val("pre_reset_data", 64'(out_data), 64'hABCDEF);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clock);
    reset = 1'b1; in_empty = 1'b1; out_ready = 1'b1;
    run_job(4, 2, 2, 0, 1'b1, -1, -1);

    for (int k = 0; k < 6; k++)
      run_job($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(1, 3), 2, 1'b0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vip_stream_sequencer.md
Name: vip_stream_sequencer

Overview:
- Frame-level controller between the pixel input FIFO and the vip processing core.
- Latches a job of width, height and num_frame, then pops exactly width*height*num_frame pixels from a show-ahead FIFO.
- Forwards the pixels through a one-entry registered output stage with a valid/ready handshake.
- Tags each beat with sof, eol and eof sideband, counts frames, and signals completion.

Parameters:
- DWIDTH, 24, pixel data width (packed RGB).
- DIM_W, 11, width of the width, height and frame-count fields.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job request; sampled only in IDLE.
- abort  in  1  synchronous job cancel.
- width  in  DIM_W  pixels per line; latched on start.
- height  in  DIM_W  lines per frame; latched on start.
- num_frame  in  DIM_W  frames per job; latched on start.
- in_data  in  DWIDTH  FIFO head word; valid while in_empty=0.
- in_empty  in  1  FIFO empty.
- in_rdreq  out  1  FIFO pop (combinational).
- out_data  out  DWIDTH  pixel to core.
- out_valid  out  1  out_data and sideband valid.
- out_ready  in  1  core accepts the current beat.
- out_sof  out  1  first pixel of a frame.
- out_eol  out  1  last pixel of a line.
- out_eof  out  1  last pixel of a frame.
- frame_idx  out  DIM_W  index of the frame currently being popped, 0-based.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when the job completes.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
Reset (reset=0, asynchronous)
- state=IDLE.
- All outputs 0, all counters 0, output register empty.

State machine: IDLE, RUN, FLUSH, DONE.
- IDLE, start=1:
  - Latch width, height and num_frame.
  - If any of them is 0: pulse cfg_err, stay in IDLE, pop nothing.
  - Otherwise: x=y=0, frame_idx=0, go to RUN.
- RUN: pop rule.
  - load = (!out_valid || out_ready) && !in_empty.
  - in_rdreq = load; in_rdreq is never asserted outside RUN.
- RUN: on load, out_data<=in_data and out_valid<=1 on the next edge.
  - Sideband is registered with the data:
    - out_sof = (x==0 && y==0)
    - out_eol = (x==width-1)
    - out_eof = out_eol && (y==height-1)
  - Latency is 1 cycle from pop to out_valid.
- RUN: counter advance on each pop.
  - x increments.
  - At x==width-1: x=0, y increments.
  - At y==height-1 on the same pop: y=0, frame_idx increments.
  - The pop with eof in the final frame (frame_idx==num_frame-1) goes to FLUSH; frame_idx does not increment on that pop.
- Output handshake:
  - If out_valid=1 and out_ready=1 with no load on the same edge, out_valid<=0.
  - Accept and reload on the same edge is allowed, sustaining 1 beat/cycle.
  - If out_valid=1 and out_ready=0, out_data and all sideband hold stable.
- FLUSH: on out_valid && out_ready, go to DONE. No pops in FLUSH.
- DONE: done=1 for one cycle, then IDLE; busy=0 in IDLE.
- abort=1 in any non-IDLE state:
  - Next edge: IDLE, out_valid=0, counters cleared.
  - No done pulse.
  - Any beat still held in the output register is dropped.
  - abort wins over any pop on the same cycle.
- start while busy is ignored.
- in_empty mid-frame: no pop, counters hold, and out_valid drops once the held beat is accepted.
- Width rules:
  - Counters are DIM_W bits.
  - The width-1 / height-1 compares use the latched values.
  - width=1 gives eol on every beat; width=1 and height=1 gives sof, eol and eof on every beat.

Test Plan:
1. Nominal job: width=4, height=2, num_frame=2, FIFO never empty, out_ready=1, data 0..15.
   - Expect 16 beats back-to-back.
   - sof on beats 0 and 8; eol on 3,7,11,15; eof on 7 and 15.
   - done pulses exactly one cycle after beat 15 is accepted.
   - frame_idx=1 during beats 8-15.
2. Backpressure: same job, out_ready toggling 1,0,0,1.
   - out_data and sideband are stable while out_ready=0.
   - No pop occurs while the register is full and out_ready=0.
   - Output order and values are unchanged from scenario 1.
3. FIFO starvation: in_empty=1 for 5 cycles after beat 5.
   - in_rdreq stays 0 throughout the gap.
   - out_valid falls after beat 5 is accepted and resumes with beat 6.
   - Counters and sideband are correct; total is still 16 beats.
4. Degenerate sizes:
   - width=1, height=1, num_frame=3: 3 beats, each with sof=eol=eof=1, then done.
   - start with height=0: cfg_err pulses, busy stays 0, in_rdreq=0.
5. Abort: abort asserted during beat 6 of scenario 1.
   - Next cycle busy=0, out_valid=0, no done pulse.
   - A following start runs a clean 16-beat job from sof.
6. Async reset: reset asserted mid-frame with out_ready=0.
   - All outputs go to 0 immediately, without waiting for a clock edge.
   - After reset is released, start is accepted normally.
